// File: rtl/clk_div_pkg.sv
// Shared constants and the per-channel state encoding for the multi-channel clock divider.
// Pure definitions: no latency, no flow control.
package clk_div_pkg;

  localparam int          CNT_W_DEF       = 26;
  localparam int unsigned DEFAULT_DIV_DEF = 10_000_000;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_PEND
  } chan_st_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: tick every div enabled cycles, 50% slowclk, shadowed divisor swap at terminal count.
// Outputs registered (1-cycle); wr_i must only be raised while pending_o is low.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             pending_o,
  output logic             tick_o,
  output logic             slowclk_o
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] div_nxt_q, div_nxt_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             slow_q, slow_d;
  logic             apply;
  logic             term;
  chan_st_e         st;

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    div_nxt_d = div_nxt_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    slow_d    = slow_q;
    apply     = 1'b0;

    if (!en_i)       st = ST_HOLD;
    else if (pend_q) st = ST_PEND;
    else             st = ST_RUN;

    term = (div_q != '0) && (cnt_q >= div_q - CNT_W'(1));

    if (sync_i) begin
      cnt_d  = '0;
      slow_d = 1'b0;
      apply  = pend_q;
    end else begin
      unique case (st)
        ST_HOLD: begin
          apply = pend_q;
          // Keep cnt inside the new period if the divisor shrinks while frozen.
          if (pend_q && (cnt_q >= div_nxt_q)) cnt_d = '0;
        end
        ST_RUN, ST_PEND: begin
          if (div_q == '0) begin
            cnt_d = '0;
            apply = pend_q;
          end else if (term) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            slow_d = ~slow_q;
            apply  = pend_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    if (apply) begin
      div_d  = div_nxt_q;
      pend_d = 1'b0;
    end
    // A write can only land while nothing is pending, so it never collides with apply.
    if (wr_i) begin
      div_nxt_d = wr_div_i;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      div_q     <= DIV_RST;
      div_nxt_q <= DIV_RST;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      slow_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      div_nxt_q <= div_nxt_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      slow_q    <= slow_d;
    end
  end

  assign pending_o = pend_q;
  assign tick_o    = tick_q;
  assign slowclk_o = slow_q;

endmodule

// File: rtl/clk_div_multi.sv
// CHANNELS independent programmable dividers with a shared valid/ready divisor config port.
// Ticks registered; cfg_ready drops while the addressed channel holds an unapplied divisor.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          CHANNELS    = 4,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int         CH_W        = ch_w(CHANNELS)
) (
  input  logic                fastclk_i,
  input  logic                rst_n_i,
  input  logic [CHANNELS-1:0] en_i,
  input  logic                sync_i,
  input  logic                cfg_valid_i,
  input  logic [CH_W-1:0]     cfg_ch_i,
  input  logic [CNT_W-1:0]    cfg_div_i,
  output logic                cfg_ready_o,
  output logic [CHANNELS-1:0] tick_o,
  output logic [CHANNELS-1:0] slowclk_o
);

  logic [CHANNELS-1:0] wr;
  logic [CHANNELS-1:0] pend;

  // Addresses beyond CHANNELS match nothing: ready stays high and the write is dropped.
  always_comb begin
    cfg_ready_o = 1'b1;
    wr          = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_ch_i == CH_W'(i)) begin
        cfg_ready_o = !pend[i];
        wr[i]       = cfg_valid_i && !pend[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i     (fastclk_i),
      .rst_n_i   (rst_n_i),
      .en_i      (en_i[g]),
      .sync_i    (sync_i),
      .wr_i      (wr[g]),
      .wr_div_i  (cfg_div_i),
      .pending_o (pend[g]),
      .tick_o    (tick_o[g]),
      .slowclk_o (slowclk_o[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench: expected tick cycles/slowclk levels are queued per channel as stimulus is issued,
// and a negedge monitor pops and compares them whenever a tick is due or seen.
module tb_clk_div_multi;

  localparam int CH = 3;
  localparam int CW = 8;
  localparam int DD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] en;
  logic          sync;
  logic          cfg_valid;
  logic [1:0]    cfg_ch;
  logic [CW-1:0] cfg_div;
  logic          cfg_ready;
  logic [CH-1:0] tick;
  logic [CH-1:0] slowclk;

  int cyc;
  int n_chk  = 0;
  int n_pass = 0;
  int acc;

  typedef struct {
    int   cyc;
    logic slow;
  } ev_t;
  ev_t exp_q[CH][$];

  clk_div_multi #(
    .CHANNELS    (CH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DD)
  ) dut (
    .fastclk_i   (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .sync_i      (sync),
    .cfg_valid_i (cfg_valid),
    .cfg_ch_i    (cfg_ch),
    .cfg_div_i   (cfg_div),
    .cfg_ready_o (cfg_ready),
    .tick_o      (tick),
    .slowclk_o   (slowclk)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp_v, cyc);
  endtask

  task automatic exp_run(input int c, input int first, input int step, input int n, input logic s0);
    for (int i = 0; i < n; i++) begin
      ev_t e;
      e.cyc  = first + i * step;
      e.slow = s0 ^ i[0];
      exp_q[c].push_back(e);
    end
  endtask

  task automatic wait_cyc(input int k);
    int guard;
    guard = 0;
    while (cyc != k && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [CW-1:0] d);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = d;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int c = 0; c < CH; c++) begin
        logic due;
        due = (exp_q[c].size() > 0) && (exp_q[c][0].cyc == cyc);
        if (tick[c] || due) begin
          chk($sformatf("tick_ch%0d", c), 32'(tick[c]), 32'(due));
          if (due) begin
            if (tick[c]) chk($sformatf("slowclk_ch%0d", c), 32'(slowclk[c]), 32'(exp_q[c][0].slow));
            void'(exp_q[c].pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    en        = 3'b011;
    sync      = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = '0;
    exp_run(0, 4, 4, 3, 1'b1);
    exp_run(1, 4, 4, 2, 1'b1);

    #12;
    chk("reset_tick", 32'(tick), 32'(0));
    chk("reset_slowclk", 32'(slowclk), 32'(0));
    chk("reset_cfg_ready", 32'(cfg_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // ch1 -> D=3, accepted at edge 5, swapped at ch1's terminal count on edge 8
    wait_cyc(4);
    cfg(2'd1, 8'd3);
    chk("rdy_ch1_idle", 32'(cfg_ready), 32'(1));
    exp_run(1, 11, 3, 11, 1'b1);
    wait_cyc(5);
    cfg_valid = 1'b0;
    chk("rdy_ch1_pend_c5", 32'(cfg_ready), 32'(0));
    wait_cyc(7);
    chk("rdy_ch1_pend_c7", 32'(cfg_ready), 32'(0));
    wait_cyc(8);
    chk("rdy_ch1_applied", 32'(cfg_ready), 32'(1));

    // ch0 back-to-back: D=2 accepted at 9, D=5 stalls until the swap at 12
    cfg(2'd0, 8'd2);
    exp_run(0, 14, 1, 1, 1'b0);
    exp_run(0, 19, 5, 2, 1'b1);
    wait_cyc(9);
    cfg_div = 8'd5;
    chk("rdy_ch0_pend", 32'(cfg_ready), 32'(0));
    acc = 0;
    for (int i = 0; i < 20 && acc == 0; i++) begin
      @(posedge clk);
      #1;
      if (cfg_ready) acc = cyc + 1;
    end
    wait_cyc(13);
    cfg_valid = 1'b0;
    chk("b2b_accept_edge", 32'(acc), 32'(13));
    chk("rdy_ch0_second_pend", 32'(cfg_ready), 32'(0));
    wait_cyc(14);
    chk("rdy_ch0_second_applied", 32'(cfg_ready), 32'(1));

    // ch0 frozen at cnt=2 for edges 27..36, D=5 -> next tick at 39
    wait_cyc(26);
    en[0] = 1'b0;
    exp_run(0, 39, 5, 1, 1'b1);
    wait_cyc(28);
    cfg(2'd3, 8'd1);
    chk("rdy_out_of_range", 32'(cfg_ready), 32'(1));
    wait_cyc(29);
    cfg_valid = 1'b0;
    wait_cyc(36);
    en[0] = 1'b1;

    // sync on the shared terminal edge 44, plus ch2 write latched as pending
    wait_cyc(43);
    sync  = 1'b1;
    en[2] = 1'b1;
    cfg(2'd2, 8'd2);
    chk("rdy_ch2_sync", 32'(cfg_ready), 32'(1));
    exp_run(0, 49, 5, 4, 1'b1);
    exp_run(1, 47, 3, 7, 1'b1);
    exp_run(2, 48, 2, 3, 1'b1);
    wait_cyc(44);
    sync      = 1'b0;
    cfg_valid = 1'b0;
    chk("rdy_ch2_pend_after_sync", 32'(cfg_ready), 32'(0));

    // ch2: D=0 stops it at 54, D=1 restarts with a tick every cycle from 60
    wait_cyc(52);
    cfg(2'd2, 8'd0);
    chk("rdy_ch2_d0", 32'(cfg_ready), 32'(1));
    exp_run(2, 54, 1, 1, 1'b0);
    wait_cyc(53);
    cfg_valid = 1'b0;
    wait_cyc(57);
    cfg(2'd2, 8'd1);
    chk("rdy_ch2_stopped", 32'(cfg_ready), 32'(1));
    exp_run(2, 60, 1, 8, 1'b1);
    wait_cyc(58);
    cfg_valid = 1'b0;

    // staged write on ch1, then reset mid-operation drops it
    wait_cyc(66);
    cfg(2'd1, 8'd7);
    wait_cyc(67);
    cfg_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rdy_ch1_staged", 32'(cfg_ready), 32'(0));
    rst_n = 1'b0;
    #1;
    chk("midreset_tick", 32'(tick), 32'(0));
    chk("midreset_slowclk", 32'(slowclk), 32'(0));
    chk("midreset_cfg_ready", 32'(cfg_ready), 32'(1));

    for (int c = 0; c < CH; c++)
      chk($sformatf("missing_ticks_ch%0d", c), 32'(exp_q[c].size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised, multi-channel successor to the single fixed-rate display clock divider. Generates CHANNELS independent divided outputs from the 50 MHz `fastclk`, each with a one-cycle `tick` (clock enable, preferred for downstream logic) and a 50 %-duty `slowclk` toggle. Divisors are runtime-programmable through a valid/ready config port, with glitch-free updates at each channel's terminal count. The block sits at the top of the board design, feeding display scan, debounce and CPU single-step logic.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1–16).
- `CNT_W`, 26: counter and divisor width in bits.
- `DEFAULT_DIV`, 10000000: divisor loaded into every channel at reset; must fit in CNT_W.

- `fastclk`  in  1: system clock (50 MHz). The block has one clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `en`  in  CHANNELS: per-channel run enable.
- `sync`  in  1: one-cycle pulse that restarts all channels in phase.
- `cfg_valid`  in  1: config request valid.
- `cfg_ch`  in  $clog2(CHANNELS) (min 1): target channel.
- `cfg_div`  in  CNT_W: new divisor D.
- `cfg_ready`  out  1: config request can be accepted.
- `tick`  out  CHANNELS: one-cycle pulse every D enabled cycles.
- `slowclk`  out  CHANNELS: toggles on every tick; period 2·D cycles.

## Operation
- Per channel: `cnt` (CNT_W), active divisor `div`, shadow `div_nxt`, `pending` flag.
- States per channel: HOLD (`en`=0), RUN (`en`=1, no pending), PEND (`en`=1, pending).
- RUN/PEND: if `cnt == div-1`, then `cnt`←0, `tick`←1, `slowclk`←~`slowclk`; else `cnt`←`cnt`+1, `tick`←0.
- Terminal count in PEND: `div`←`div_nxt`, `pending`←0, go to RUN, same edge as the tick.
- HOLD: `cnt`, `slowclk` frozen, `tick`←0. A pending update is applied on the next edge (`div`←`div_nxt`, `pending`←0).
- `div`=0 means stopped: no ticks, `cnt` held at 0, `slowclk` frozen. A write to a stopped channel applies on the next edge.
- Config handshake: transfer occurs on an edge with `cfg_valid`&&`cfg_ready`. Then `div_nxt[cfg_ch]`←`cfg_div` and `pending[cfg_ch]`←1.
- `cfg_ready` = !`pending[cfg_ch]` (combinational on `cfg_ch`). A second write to the same channel stalls until the first is applied.
- `cfg_ch` ≥ CHANNELS: `cfg_ready`=1, write discarded.
- `sync`: every channel `cnt`←0, `slowclk`←0, `tick`←0. Any pending update is applied immediately. `sync` overrides terminal count and config on the same edge.
- A config write accepted on the same edge as `sync` is latched as pending and applied at the next terminal count.
- Width rule: `cnt` never exceeds `div`-1. Changing to a smaller divisor is safe because it only takes effect at `cnt`=0.

## Timing
- Reset (async assert, sync-release by the external reset synchroniser): `cnt`=0, `div`=DEFAULT_DIV, `pending`=0, `tick`=0, `slowclk`=0, `cfg_ready`=1.
- `tick` and `slowclk` are registered. With `en`=1 from reset release, the first `tick` is high in the cycle after the D-th rising edge, then every D cycles.
- D=1: `tick` constant high, `slowclk` toggles every cycle.
- `en` deassert/reassert: counting resumes from the frozen `cnt`; phase is otherwise preserved.
- New divisor latency: applied at the terminal count following acceptance. The first period at the new rate starts on that edge.
- Reset mid-operation: all state returns to reset values immediately; staged writes are lost.

## Structure
- Package `clk_div_pkg`: default CNT_W/DEFAULT_DIV constants and the channel state enum (HOLD/RUN/PEND).
- Sub-module `clk_div_chan`: one channel (counter, div, shadow, pending, outputs). The top instantiates CHANNELS copies via generate, plus the config decode and `cfg_ready` mux.

## Test plan
- Reset with CHANNELS=2, DEFAULT_DIV=4, en=2'b11 → ticks on cycles 4, 8, 12; slowclk is 0→1 at 4, 1→0 at 8.
- Write ch1 D=3 at cycle 5 → ch1 ticks at 8 (old period), then 11, 14; `cfg_ready` for ch1 low between cycles 6 and 8.
- Back-to-back write to ch0 while pending → `cfg_ready`=0, no transfer until the terminal count, then the second write is accepted.
- `en[0]` low for 10 cycles at cnt=2 → no ticks; after re-enable, first tick 2 cycles later (D=4).
- `sync` pulse coincident with ch0 terminal count → no tick; all cnt=0, slowclk=0; next tick D cycles later on all channels.
- Write D=0 then D=1 → channel stops (no ticks, slowclk frozen); after D=1, tick is high every cycle from the next edge.
